// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   Sequences a dynamic divider change on an rPLL. The downstream clock is
//   gated, the new idsel/fbdsel is applied, and the controller waits for
//   relock before re-enabling consumers.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   req       in   reconfiguration request strobe
//   mode[1:0] in   target mode, sampled with req
//   idsel     out  registered input-divider select (63 - IDIV_n)
//   fbdsel    out  registered feedback-divider select (63 - FBDIV_n)
//   clk_en    out  enable for consumers of the PLL clock
//   busy      out  change or settle in progress
//   done      out  one-cycle pulse when a request completes
//   cur_mode  out  mode currently applied
//
// state  | meaning
// IDLE   | PLL locked, consumers enabled, waiting for a request
// GATE   | consumers gated, lead time before the divider change
// APPLY  | single cycle that registers the new divider selects
// SETTLE | waiting for relock (also used after reset)
module pll_reconfig_ctrl #(
  parameter int GATE_LEAD     = 4,
  parameter int SETTLE_CYCLES = 4096,
  parameter int IDIV_0        = 2,
  parameter int IDIV_1        = 2,
  parameter int IDIV_2        = 2,
  parameter int IDIV_3        = 2,
  parameter int FBDIV_0       = 13,
  parameter int FBDIV_1       = 11,
  parameter int FBDIV_2       = 15,
  parameter int FBDIV_3       = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] mode,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic       clk_en,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_mode
);

  typedef enum logic [1:0] {IDLE, GATE, APPLY, SETTLE} state_t;

  state_t      state;
  logic [7:0]  gate_cnt;
  logic [15:0] settle_cnt;
  logic        pend_vld;
  logic [1:0]  pend_mode;
  logic [1:0]  tgt_mode;
  logic        boot;       // current SETTLE follows reset: no done pulse
  logic        svc_vld;
  logic [1:0]  svc_mode;

  function automatic logic [5:0] idsel_enc(input logic [1:0] m);
    case (m)
      2'd0:    return 6'(63 - IDIV_0);
      2'd1:    return 6'(63 - IDIV_1);
      2'd2:    return 6'(63 - IDIV_2);
      default: return 6'(63 - IDIV_3);
    endcase
  endfunction

  function automatic logic [5:0] fbdsel_enc(input logic [1:0] m);
    case (m)
      2'd0:    return 6'(63 - FBDIV_0);
      2'd1:    return 6'(63 - FBDIV_1);
      2'd2:    return 6'(63 - FBDIV_2);
      default: return 6'(63 - FBDIV_3);
    endcase
  endfunction

  // In IDLE a live strobe wins over the pending slot: a strobe on the first
  // IDLE cycle is the newest request and overwrites anything queued.
  always_comb begin
    svc_vld  = req | pend_vld;
    svc_mode = req ? mode : pend_mode;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SETTLE;
      gate_cnt   <= '0;
      settle_cnt <= 16'(SETTLE_CYCLES - 1);
      pend_vld   <= 1'b0;
      pend_mode  <= 2'd0;
      tgt_mode   <= 2'd0;
      boot       <= 1'b1;
      idsel      <= idsel_enc(2'd0);
      fbdsel     <= fbdsel_enc(2'd0);
      cur_mode   <= 2'd0;
      clk_en     <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (busy && req) begin
        pend_vld  <= 1'b1;
        pend_mode <= mode;
      end

      case (state)
        IDLE: begin
          if (svc_vld) begin
            pend_vld <= 1'b0;
            if (svc_mode != cur_mode) begin
              state    <= GATE;
              tgt_mode <= svc_mode;
              gate_cnt <= 8'(GATE_LEAD - 1);
              busy     <= 1'b1;
              clk_en   <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        GATE: begin
          if (gate_cnt == 8'd0) state <= APPLY;
          else                  gate_cnt <= gate_cnt - 8'd1;
        end
        APPLY: begin
          state      <= SETTLE;
          settle_cnt <= 16'(SETTLE_CYCLES - 1);
          idsel      <= idsel_enc(tgt_mode);
          fbdsel     <= fbdsel_enc(tgt_mode);
          cur_mode   <= tgt_mode;
        end
        SETTLE: begin
          if (settle_cnt == 16'd0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            clk_en <= 1'b1;
            done   <= ~boot;
            boot   <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [1:0] mode;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic       clk_en;
  logic       busy;
  logic       done;
  logic [1:0] cur_mode;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .GATE_LEAD    (4),
    .SETTLE_CYCLES(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .mode    (mode),
    .idsel   (idsel),
    .fbdsel  (fbdsel),
    .clk_en  (clk_en),
    .busy    (busy),
    .done    (done),
    .cur_mode(cur_mode)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven after this are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a change to m0 at cycle 0 and optionally pulses req at cycles
  // ca/cb with modes ma/mb. Records the cycles of the first two done pulses.
  task automatic run_seq(input logic [1:0] m0,
                         input int ca, input logic [1:0] ma,
                         input int cb, input logic [1:0] mb,
                         output int d1, output int d2, output int dcnt,
                         output bit busy23, output bit saw2);
    d1 = -1; d2 = -1; dcnt = 0; busy23 = 1'b0; saw2 = 1'b0;
    req = 1'b1; mode = m0;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (done === 1'b1) begin
        dcnt++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (cur_mode == 2'd2) saw2 = 1'b1;
      if (c == 23) busy23 = busy & ~clk_en;
      req  = (c == ca) || (c == cb);
      mode = (c == ca) ? ma : ((c == cb) ? mb : 2'd0);
      tick();
    end
    req = 1'b0;
  endtask

  initial begin
    int  d1, d2, dcnt;
    bit  b23, saw2;

    reset = 1'b1; req = 1'b0; mode = 2'd0;
    repeat (3) tick();
    check_val("rst_idsel",    idsel,    61);
    check_val("rst_fbdsel",   fbdsel,   50);
    check_val("rst_cur_mode", cur_mode, 0);
    check_val("rst_clk_en",   clk_en,   0);
    check_val("rst_busy",     busy,     1);
    check_val("rst_done",     done,     0);

    // Boot settle: 16 busy cycles, then idle without done.
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_val("boot_busy",   busy,   1);
      check_val("boot_clk_en", clk_en, 0);
      check_val("boot_done",   done,   0);
      tick();
    end
    check_val("boot_end_busy",   busy,     0);
    check_val("boot_end_clk_en", clk_en,   1);
    check_val("boot_end_done",   done,     0);
    check_val("boot_end_idsel",  idsel,    61);
    check_val("boot_end_fbdsel", fbdsel,   50);
    check_val("boot_end_mode",   cur_mode, 0);

    // Same-mode request: immediate done, nothing else moves.
    req = 1'b1; mode = 2'd0;
    tick();
    req = 1'b0;
    check_val("same_done",   done,   1);
    check_val("same_busy",   busy,   0);
    check_val("same_idsel",  idsel,  61);
    check_val("same_fbdsel", fbdsel, 50);
    tick();
    check_val("same_done_clr", done, 0);
    check_val("same_busy2",    busy, 0);

    // Change to mode 1: gated cycles 1..21, new fbdsel from cycle 6.
    req = 1'b1; mode = 2'd1;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      check_val("m1_clk_en", clk_en, 0);
      check_val("m1_busy",   busy,   1);
      check_val("m1_done",   done,   0);
      check_val("m1_fbdsel", fbdsel, (c >= 6) ? 52 : 50);
      check_val("m1_mode",   cur_mode, (c >= 6) ? 1 : 0);
      tick();
    end
    check_val("m1_end_done",   done,   1);
    check_val("m1_end_clk_en", clk_en, 1);
    check_val("m1_end_busy",   busy,   0);
    check_val("m1_end_fbdsel", fbdsel, 52);
    check_val("m1_end_idsel",  idsel,  61);
    tick();
    check_val("m1_done_clr", done, 0);

    // Change to 0 with reqs for 2 then 3 while busy: 3 overwrites 2.
    run_seq(2'd0, 3, 2'd2, 8, 2'd3, d1, d2, dcnt, b23, saw2);
    check_val("pend_d1",      d1,       22);
    check_val("pend_d2",      d2,       44);
    check_val("pend_dcnt",    dcnt,     2);
    check_val("pend_restart", b23,      1);
    check_val("pend_no_m2",   saw2,     0);
    check_val("pend_fbdsel",  fbdsel,   54);
    check_val("pend_idsel",   idsel,    61);
    check_val("pend_mode",    cur_mode, 3);
    check_val("pend_busy",    busy,     0);

    // Change to 1, then req for 2 on the cycle busy falls.
    run_seq(2'd1, 22, 2'd2, -1, 2'd0, d1, d2, dcnt, b23, saw2);
    check_val("fall_d1",     d1,       22);
    check_val("fall_d2",     d2,       44);
    check_val("fall_dcnt",   dcnt,     2);
    check_val("fall_start",  b23,      1);
    check_val("fall_fbdsel", fbdsel,   48);
    check_val("fall_mode",   cur_mode, 2);

    // Reset during SETTLE of a mode-3 change, with a request pending.
    req = 1'b1; mode = 2'd3;
    tick();
    req = 1'b0;
    for (int c = 1; c < 10; c++) begin
      req  = (c == 8);
      mode = (c == 8) ? 2'd1 : 2'd0;
      tick();
    end
    req = 1'b0;
    check_val("abort_pre_fbdsel", fbdsel,   54);
    check_val("abort_pre_mode",   cur_mode, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_idsel",  idsel,    61);
    check_val("abort_fbdsel", fbdsel,   50);
    check_val("abort_mode",   cur_mode, 0);
    check_val("abort_clk_en", clk_en,   0);
    check_val("abort_busy",   busy,     1);
    for (int i = 0; i < 16; i++) begin
      check_val("abort_settle_busy", busy, 1);
      check_val("abort_settle_done", done, 0);
      tick();
    end
    check_val("abort_end_busy",   busy,   0);
    check_val("abort_end_clk_en", clk_en, 1);
    check_val("abort_end_done",   done,   0);
    repeat (3) begin
      tick();
      check_val("abort_no_pend_busy", busy,     0);
      check_val("abort_no_pend_done", done,     0);
      check_val("abort_no_pend_mode", cur_mode, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_LEAD, default 4, meaning consumer-clock gate lead cycles before the divider change (range 1..255).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4096, meaning PLL relock wait cycles after a divider change (range 2..65535).
REQ-003 The block SHALL have parameters IDIV_0..IDIV_3, defaults 2,2,2,2, meaning 6-bit input-divider setting for mode 0..3.
REQ-004 The block SHALL have parameters FBDIV_0..FBDIV_3, defaults 13,11,15,9, meaning 6-bit feedback-divider setting for mode 0..3.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port req, input, 1 bit, reconfiguration request (single-cycle strobe).
REQ-008 The block SHALL have port mode, input, 2 bits, target mode, sampled with req.
REQ-009 The block SHALL have port idsel, output, 6 bits, registered dynamic input-divider select to the rPLL.
REQ-010 The block SHALL have port fbdsel, output, 6 bits, registered dynamic feedback-divider select to the rPLL.
REQ-011 The block SHALL have port clk_en, output, 1 bit, enable for downstream consumers of the PLL clock.
REQ-012 The block SHALL have port busy, output, 1 bit, reconfiguration or settle in progress.
REQ-013 The block SHALL have port done, output, 1 bit, one-cycle pulse when a request completes.
REQ-014 The block SHALL have port cur_mode, output, 2 bits, mode currently applied.

Function
REQ-015 Encoding SHALL be idsel = 63 - IDIV_n and fbdsel = 63 - FBDIV_n, 6-bit unsigned, for the applied mode n.
REQ-016 The FSM SHALL have states IDLE, GATE, APPLY, SETTLE; SETTLE counter is 16-bit, GATE counter is 8-bit.
REQ-017 In IDLE with req=1 and mode != cur_mode: next state GATE, busy=1, clk_en=0 from the next cycle.
REQ-018 In IDLE with req=1 and mode == cur_mode: no state change, dividers untouched, done=1 on the next cycle.
REQ-019 GATE SHALL last exactly GATE_LEAD cycles, then go to APPLY for exactly 1 cycle.
REQ-020 idsel/fbdsel/cur_mode SHALL take the new values on the first SETTLE cycle.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to IDLE with clk_en=1, busy=0, and done=1 for that one cycle.
REQ-022 Busy duration for a mode change SHALL be GATE_LEAD + 1 + SETTLE_CYCLES cycles.
REQ-023 A req while busy=1 SHALL load a one-deep pending slot (latest mode overwrites); it is serviced as an IDLE request on the cycle IDLE is entered, with no done for the overwritten request.
REQ-024 A req on the same cycle busy falls SHALL be treated as pending (serviced next cycle).
REQ-025 done SHALL never be asserted for two consecutive cycles except when a same-mode request (REQ-018) immediately follows completion.

Reset
REQ-026 On reset, outputs SHALL be: idsel=63-IDIV_0, fbdsel=63-FBDIV_0, cur_mode=0, clk_en=0, busy=1, done=0; pending slot cleared.
REQ-027 After reset deasserts, the FSM SHALL enter SETTLE, run SETTLE_CYCLES cycles, then enter IDLE with clk_en=1 and busy=0, without a done pulse.
REQ-028 Reset asserted mid-operation (any state) SHALL abort it and apply REQ-026/027 on the next edge; the in-flight and pending requests are discarded.

Verification (GATE_LEAD=4, SETTLE_CYCLES=16)
REQ-029 Release reset -> busy=1/clk_en=0 for 16 cycles; then idsel=61, fbdsel=50, cur_mode=0, busy=0, no done.
REQ-030 req at cycle 0 with mode=1 in IDLE -> clk_en=0 at cycles 1..21; fbdsel=52 from cycle 6; done=1 and clk_en=1 at cycle 22.
REQ-031 req with mode=0 while cur_mode=0 -> done=1 next cycle; busy stays 0; idsel/fbdsel unchanged.
REQ-032 req mode=2 then mode=3 during busy -> after the first completion (done), the mode-3 change starts the next cycle; final fbdsel=54 with a single second done; mode 2 is never applied.
REQ-033 Reset during SETTLE of a mode-3 change -> the outputs return to mode-0 encoding next cycle; 16-cycle settle; no done pulse.
